data_ram_writer: RTL and testbench

- Write-side loader for the banked feature-map store: 32 single-port byte RAMs, one per image column, addressed by image row.
- Accepts a raster-order pixel stream over a valid/ready handshake.
- Routes each pixel to bank = column index, address = row index.
- Signals completion so the strided window reader may start fetching.

---
 rtl/data_ram_writer_pkg.sv | 14 +
 rtl/data_ram_writer_if.sv | 24 ++
 rtl/data_ram_writer_raster_counter.sv | 29 ++
 rtl/data_ram_writer.sv | 80 ++++++++
 tb/tb_data_ram_writer.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/data_ram_writer_pkg.sv
// data_ram_pkg: shared sizes, writer state encoding and bank one-hot decode for the feature-map loader.
package data_ram_pkg;
  localparam int DW = 8;
  localparam int RAM_NUM = 32;
  localparam int RAM_SIZE = 32;
  localparam int ADDR_DW = $clog2(RAM_SIZE);
  localparam int CNT_W = ADDR_DW + 1;
  localparam logic [CNT_W-1:0] NUM_MAX = CNT_W'(RAM_NUM);
  localparam logic [CNT_W-1:0] SIZE_MAX = CNT_W'(RAM_SIZE);
  typedef enum logic [1:0] {IDLE, LOAD, PAD, DONE} wr_state_e;
  function automatic logic [RAM_NUM-1:0] bank_sel(input logic [CNT_W-1:0] c);
    return {{(RAM_NUM-1){1'b0}}, 1'b1} << c;
  endfunction
endpackage

// File: rtl/data_ram_writer_if.sv
// data_ram_writer_if: control, pixel stream and bank write port of the feature-map loader.
interface data_ram_writer_if;
  import data_ram_pkg::*;
  logic start;
  logic [CNT_W-1:0] img_width;
  logic [CNT_W-1:0] img_height;
  logic in_valid;
  logic [DW-1:0] in_data;
  logic in_ready;
  logic [RAM_NUM-1:0] wr_en;
  logic [ADDR_DW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic busy;
  logic done;
  logic cfg_err;
  modport master (
    output start, img_width, img_height, in_valid, in_data,
    input in_ready, wr_en, wr_addr, wr_data, busy, done, cfg_err
  );
  modport slave (
    input start, img_width, img_height, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, busy, done, cfg_err
  );
endinterface

// File: rtl/data_ram_writer_raster_counter.sv
// raster_counter: raster-order column/row counter with end-of-row and last-row flags.
module raster_counter
  import data_ram_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic adv,
  input  logic [CNT_W-1:0] w,
  input  logic [CNT_W-1:0] h,
  output logic [CNT_W-1:0] col,
  output logic [ADDR_DW-1:0] row_addr,
  output logic eor,
  output logic row_last
);
  logic [CNT_W-1:0] row;
  assign eor = col == w - CNT_W'(1);
  assign row_last = row == h - CNT_W'(1);
  assign row_addr = row[ADDR_DW-1:0];
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      col <= eor ? '0 : col + CNT_W'(1);
      row <= eor ? row + CNT_W'(1) : row;
    end
  end
endmodule

// File: rtl/data_ram_writer.sv
// data_ram_writer: routes a raster pixel stream into per-column byte banks; DATA_RAM_WRITER_ZERO_PAD_EN zero-fills unused banks per row.
module data_ram_writer
  import data_ram_pkg::*;
(
  input logic clk,
  input logic rst,
  data_ram_writer_if.slave bus
);
  wr_state_e state;
  logic [CNT_W-1:0] w, h, col;
  logic [ADDR_DW-1:0] row_addr;
  logic eor, row_last, hs, bad, accept;
`ifdef DATA_RAM_WRITER_ZERO_PAD_EN
  logic [CNT_W-1:0] pad_col;
  logic pad_last;
`endif
  assign bad = bus.img_width == '0 || bus.img_width > NUM_MAX ||
               bus.img_height == '0 || bus.img_height > SIZE_MAX;
  assign accept = state == IDLE && bus.start && !bad;
  assign bus.in_ready = state == LOAD;
  assign bus.busy = state == LOAD || state == PAD;
  assign bus.done = state == DONE;
  assign hs = bus.in_valid && bus.in_ready;
  raster_counter u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(accept),
    .adv(hs),
    .w(w),
    .h(h),
    .col(col),
    .row_addr(row_addr),
    .eor(eor),
    .row_last(row_last)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      w <= '0;
      h <= '0;
      bus.wr_en <= '0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.cfg_err <= 1'b0;
`ifdef DATA_RAM_WRITER_ZERO_PAD_EN
      pad_col <= '0;
      pad_last <= 1'b0;
`endif
    end else begin
      bus.wr_en <= hs ? bank_sel(col) : '0;
      bus.cfg_err <= state == IDLE && bus.start && bad;
      if (hs) begin
        bus.wr_addr <= row_addr;
        bus.wr_data <= bus.in_data;
      end
      if (accept) begin
        w <= bus.img_width;
        h <= bus.img_height;
        state <= LOAD;
      end
`ifdef DATA_RAM_WRITER_ZERO_PAD_EN
      if (hs && eor && w != NUM_MAX) begin
        state <= PAD;
        pad_col <= w;
        pad_last <= row_last;
      end else if (hs && eor && row_last) state <= DONE;
      // wr_addr still holds the row just completed, so pads land on that row
      if (state == PAD) begin
        bus.wr_en <= bank_sel(pad_col);
        bus.wr_data <= '0;
        pad_col <= pad_col + CNT_W'(1);
        if (pad_col == NUM_MAX - CNT_W'(1)) state <= pad_last ? DONE : LOAD;
      end
`else
      if (hs && eor && row_last) state <= DONE;
`endif
      if (state == DONE) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_data_ram_writer.sv
// tb_data_ram_writer: table-driven frames with a write scoreboard, plus reset-mid-load and restart corner cases.
module tb_data_ram_writer;
  import data_ram_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  data_ram_writer_if bus ();
  data_ram_writer dut (.clk(clk), .rst(rst), .bus(bus));
`ifdef DATA_RAM_WRITER_ZERO_PAD_EN
  localparam bit PAD_ON = 1'b1;
`else
  localparam bit PAD_ON = 1'b0;
`endif
  typedef struct {int bank; int addr; int data;} wr_t;
  typedef struct {int w; int h; bit gap; bit restart; bit err; int exp_writes;} vec_t;
  wr_t q[$];
  logic [7:0] mem [32][32];
  int checks = 0, errors = 0, cyc = 0, nwr = 0;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    int b;
    wr_t e;
    if (!rst && bus.wr_en != '0) begin
      b = -1;
      for (int i = 0; i < 32; i++) if (bus.wr_en[i]) b = i;
      chk("wr_en onehot", int'($onehot(bus.wr_en)), 1);
      nwr++;
      mem[b][bus.wr_addr] = bus.wr_data;
      if (q.size() == 0) chk("unexpected write bank", b, -1);
      else begin
        e = q.pop_front();
        chk("wr bank", b, e.bank);
        chk("wr addr", int'(bus.wr_addr), e.addr);
        chk("wr data", int'(bus.wr_data), e.data);
      end
    end
  end
  function automatic int pix(input int c, input int r);
    return (r * 32 + c) & 255;
  endfunction
  function automatic vec_t mk(input int w, input int h, input bit gap, input bit restart, input bit err);
    vec_t v;
    v.w = w; v.h = h; v.gap = gap; v.restart = restart; v.err = err;
    v.exp_writes = err ? 0 : w * h + (PAD_ON ? h * (32 - w) : 0);
    return v;
  endfunction
  task automatic run_frame(input vec_t v);
    int p, n, n0, fc, dc, c, r;
    bit dn;
    n = v.w * v.h; n0 = nwr; fc = -1; dc = 0; p = 0;
    bus.img_width = 6'(v.w);
    bus.img_height = 6'(v.h);
    bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    if (v.err) begin
      @(negedge clk);
      chk("cfg_err pulse", bus.cfg_err, 1);
      chk("busy on cfg_err", bus.busy, 0);
      chk("in_ready on cfg_err", bus.in_ready, 0);
      @(posedge clk); @(negedge clk);
      chk("cfg_err one cycle", bus.cfg_err, 0);
      chk("busy after cfg_err", bus.busy, 0);
      chk("writes on cfg_err", nwr - n0, 0);
      return;
    end
    for (int t = 0; p < n && t < 4000; t++) begin
      c = p % v.w; r = p / v.w;
      bus.in_valid = v.gap ? (t % 2 == 0) : 1'b1;
      bus.in_data = 8'(pix(c, r));
      if (v.restart && p == 2) begin bus.start = 1'b1; bus.img_width = 6'd8; end
      @(negedge clk);
      if (t == 0) chk("busy in load", bus.busy, 1);
      if (bus.in_valid && bus.in_ready) begin
        if (fc < 0) fc = cyc;
        q.push_back('{c, r, pix(c, r)});
        if (PAD_ON && c == v.w - 1) for (int b = v.w; b < 32; b++) q.push_back('{b, r, 0});
        p++;
      end
      @(posedge clk); #1 bus.start = 1'b0;
    end
    bus.in_valid = 1'b0;
    bus.img_width = 6'(v.w);
    chk("pixels accepted", p, n);
    dn = 1'b0;
    for (int k = 0; k < 100 && !dn; k++) begin
      @(negedge clk);
      if (bus.done) begin dn = 1'b1; dc = cyc; end
      else @(posedge clk);
    end
    chk("done seen", dn, 1);
    if (!v.gap) chk("first handshake to done", dc - fc, PAD_ON ? v.h * 32 : v.w * v.h);
    @(posedge clk); @(negedge clk);
    chk("done one cycle", bus.done, 0);
    chk("busy after done", bus.busy, 0);
    chk("frame writes", nwr - n0, v.exp_writes);
    chk("scoreboard drained", q.size(), 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t v[10];
    v[0] = mk(0, 4, 0, 0, 1);
    v[1] = mk(33, 4, 0, 0, 1);
    v[2] = mk(4, 0, 0, 0, 1);
    v[3] = mk(4, 33, 0, 0, 1);
    v[4] = mk(3, 2, 1, 0, 0);
    v[5] = mk(4, 1, 0, 1, 0);
    v[6] = mk(32, 32, 0, 0, 0);
    v[7] = mk(30, 2, 0, 0, 0);
    v[8] = mk(1, 1, 0, 0, 0);
    v[9] = mk(32, 1, 1, 0, 0);
    bus.start = 1'b0; bus.img_width = '0; bus.img_height = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", bus.in_ready, 0);
    chk("reset wr_en", int'(bus.wr_en), 0);
    chk("reset wr_addr", int'(bus.wr_addr), 0);
    chk("reset wr_data", int'(bus.wr_data), 0);
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset cfg_err", bus.cfg_err, 0);
    @(posedge clk); #1 rst = 1'b0;
    bus.img_width = 6'd4; bus.img_height = 6'd2; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'(pix(k, 0));
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) q.push_back('{k, 0, pix(k, 0)});
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst mid-load in_ready", bus.in_ready, 0);
    chk("rst mid-load wr_en", int'(bus.wr_en), 0);
    chk("rst mid-load busy", bus.busy, 0);
    chk("rst mid-load writes", nwr, 3);
    chk("rst mid-load scoreboard", q.size(), 0);
    @(posedge clk); #1;
    run_frame(mk(4, 2, 0, 0, 0));
    foreach (v[i]) begin
      @(posedge clk); #1;
      run_frame(v[i]);
      if (v[i].w == 32 && v[i].h == 32) chk("bank5 addr3", int'(mem[5][3]), 'h65);
`ifdef DATA_RAM_WRITER_ZERO_PAD_EN
      if (v[i].w == 30) chk("pad bank31 addr1", int'(mem[31][1]), 0);
`endif
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
